regfile_writeback_queue: RTL

Write-side companion of the processor's 32×32 register file. Collects results from the ALU and load paths, buffers them in a small in-order queue, and drains them one per cycle onto the register file's write port (`we_RF`, `A3`, `WD3`). It also provides forwarding lookups, so the decode stage can see values that are queued but not yet written to the register file.

---
 rtl/regfile_writeback_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue between the ALU/load result paths and the register file write port.
// Drains one entry per cycle into registered we_RF/A3/WD3 and exposes forwarding of pending writes.
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [4:0]             mem_rd,
    input  logic [XLEN-1:0]        mem_data,
    output logic                   mem_ready,
    output logic                   we_RF,
    output logic [4:0]             A3,
    output logic [XLEN-1:0]        WD3,
    input  logic [4:0]             A1,
    input  logic [4:0]             A2,
    output logic                   fwd1_hit,
    output logic                   fwd2_hit,
    output logic [XLEN-1:0]        fwd1_data,
    output logic [XLEN-1:0]        fwd2_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            we_q;
    logic [4:0]      a3_q;
    logic [XLEN-1:0] wd3_q;

    logic            mem_take, alu_take, push, pop;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;
    logic [PW-1:0]   idx;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign we_RF = we_q;
    assign A3    = a3_q;
    assign WD3   = wd3_q;

    // The load path wins when both offer; rd==0 results are accepted but dropped.
    always_comb begin
        mem_ready = !rst && !full;
        alu_ready = !rst && !full && !mem_valid;
        mem_take  = mem_valid && mem_ready;
        alu_take  = alu_valid && alu_ready;
        push_rd   = mem_take ? mem_rd : alu_rd;
        push_data = mem_take ? mem_data : alu_data;
        push      = (mem_take || alu_take) && (push_rd != 5'd0);
        pop       = (count_q != '0);
        tail_d    = push ? tail_q + PW'(1) : tail_q;
        head_d    = pop ? head_q + PW'(1) : head_q;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        idx       = head_q;
        if (we_q && A1 != 5'd0 && a3_q == A1) begin
            fwd1_hit  = 1'b1;
            fwd1_data = wd3_q;
        end
        if (we_q && A2 != 5'd0 && a3_q == A2) begin
            fwd2_hit  = 1'b1;
            fwd2_data = wd3_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (A1 != 5'd0 && rd_q[idx] == A1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[idx];
                end
                if (A2 != 5'd0 && rd_q[idx] == A2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= pop;
            if (push) begin
                rd_q[tail_q]   <= push_rd;
                data_q[tail_q] <= push_data;
            end
            if (pop) begin
                a3_q  <= rd_q[head_q];
                wd3_q <= data_q[head_q];
            end
        end
    end

endmodule
